rr_mux_arb: RTL and testbench
=============================

RR_MUX_ARB -- requirements
Module: rr_mux_arb

Interface
REQ-001 Parameter N, default 8, data width in bits per channel (1..64).
REQ-002 Parameter M, default 4, channel count (2..8).
REQ-003 Parameter SW, default 2, select/index width; SHALL satisfy 2^SW >= M.
REQ-004 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1, asynchronous, active-high reset.
REQ-006 Port I, input, M*N, flattened channel data; channel k occupies bits [k*N+N-1 : k*N].
REQ-007 Port V, input, M, per-channel valid; V[k] = channel k offers data.
REQ-008 Port R, output, M, per-channel ready; R[k] = channel k's data is taken this cycle.
REQ-009 Port MD, input, 1, mode; 0 = fixed select, 1 = round-robin.
REQ-010 Port SEL, input, SW, channel index used when MD=0.
REQ-011 Port F, output, N, registered selected data.
REQ-012 Port FV, output, 1, F holds valid data.
REQ-013 Port FR, input, 1, downstream ready; F consumed on a cycle with FV=1 and FR=1.
REQ-014 Port S, output, SW, registered index of the channel whose data is in F.

Function
REQ-015 Output register SHALL be free ("load-enable") when FV=0 or FR=1.
REQ-016 When free and MD=0: grant channel SEL iff SEL<M and V[SEL]=1; otherwise no grant.
REQ-017 When free and MD=1: grant the first k with V[k]=1, searching ptr+1, ptr+2, ... modulo M, ending at ptr; none if V=0.
REQ-018 R SHALL be one-hot on the granted channel, all-zero when no grant; R is combinational from V, MD, SEL, ptr, FV, FR.
REQ-019 On a grant edge: F <= granted channel data, S <= granted index, FV <= 1; latency 1 cycle from V/R handshake to FV.
REQ-020 When free with no grant: FV <= 0; F and S retain previous values.
REQ-021 When FV=1 and FR=0 (stall): F, S, FV SHALL hold; R SHALL be all-zero.
REQ-022 Consumption and new grant in the same cycle SHALL proceed; sustained throughput is one transfer per cycle.
REQ-023 Round-robin pointer ptr (SW bits) SHALL update to the granted index on every grant in MD=1; it SHALL not change in MD=0.
REQ-024 Pointer wrap: the search index after M-1 is 0; indices >= M are never granted.
REQ-025 MD or SEL changes take effect on the next arbitration decision; a datum already in F is unaffected.
REQ-026 No channel is granted twice without an intervening edge; a channel holding V=1 in MD=1 is granted within M grants.

Reset
REQ-027 While reset=1, asynchronously: FV=0, F=0, S=0, ptr=M-1 (channel 0 highest priority first).
REQ-028 R SHALL be all-zero while reset=1.
REQ-029 Reset asserted mid-stall SHALL discard the held datum; first grant after release follows REQ-016/017.

Verification
REQ-030 Reset release, MD=1, V=4'b1111, FR=1 each cycle -> S sequence 0,1,2,3,0; FV=1 from first edge after V; R one-hot each cycle.
REQ-031 MD=1, V=4'b1010, FR=1 -> grants alternate 1,3,1,3; R[0]=R[2]=0 throughout.
REQ-032 MD=0, SEL=2, I channel 2 = 8'hA5, V[2]=1 -> next edge F=8'hA5, S=2, FV=1; SEL=2 with V[2]=0 -> FV=0 after next edge, R=0.
REQ-033 Stall: FV=1, F=8'h3C, FR=0 for 3 cycles with V=4'b1111 -> F, S constant, R=0; FR=1 -> new grant same cycle, F updates next edge.
REQ-034 Reset pulse while FV=1 and FR=0 -> FV=0, F=0, S=0 immediately; after release with V=4'b1000, MD=1 -> S=3.
REQ-035 Parameter sweep N=1/M=2/SW=1 and N=16/M=8/SW=3 -> round-robin fairness per REQ-026 over 100 random cycles; no grant of an index >= M.

Source files
------------

// File: rtl/rr_mux_arb_if.sv
// Bus bundle for rr_mux_arb: M upstream channels in, one registered
// stream out. The arbiter connects through the slave modport. The
// master modport is the view of whatever drives the channels and
// consumes the output.
interface rr_mux_arb_if #(
  parameter int N  = 8,
  parameter int M  = 4,
  parameter int SW = 2
);
  logic [M*N-1:0] I;    // flattened channel data, channel k at [k*N +: N]
  logic [M-1:0]   V;    // per-channel valid
  logic [M-1:0]   R;    // per-channel ready (one-hot grant)
  logic           MD;   // 0 = fixed select, 1 = round-robin
  logic [SW-1:0]  SEL;  // channel index used in fixed mode
  logic [N-1:0]   F;    // registered selected data
  logic           FV;   // F holds valid data
  logic           FR;   // downstream ready
  logic [SW-1:0]  S;    // index of the channel whose data is in F

  modport master (
    output I, V, MD, SEL, FR,
    input  R, F, FV, S
  );

  modport slave (
    input  I, V, MD, SEL, FR,
    output R, F, FV, S
  );
endinterface

// File: rtl/rr_mux_arb.sv
// Round-robin / fixed-select multiplexing arbiter with a single output
// register. Each cycle the output register is free when it is empty or
// being consumed. A free register takes one channel: either the channel
// named by SEL, or the next valid channel after the last one granted.
// The ready to the winning channel is combinational. The chosen datum
// appears on F one cycle after the handshake.
module rr_mux_arb #(
  parameter int N  = 8,
  parameter int M  = 4,
  parameter int SW = 2
) (
  input  logic          clk,
  input  logic          reset,
  rr_mux_arb_if.slave   bus
);

  // Output register and round-robin pointer
  logic [N-1:0]  r_f;
  logic [SW-1:0] r_s;
  logic          r_fv;
  logic [SW-1:0] r_ptr;

  // Arbitration wires
  logic [N-1:0]  w_ch_data [M];
  logic          w_free;
  logic          w_fix_found;
  logic [SW-1:0] w_fix_idx;
  logic          w_rr_found;
  logic [SW-1:0] w_rr_idx;
  logic          w_gnt;
  logic [SW-1:0] w_gnt_idx;
  logic [M-1:0]  w_gnt_oh;
  logic [N-1:0]  w_gnt_data;

  // Unpack the flattened channel bus into one word per channel
  generate
    for (genvar gi = 0; gi < M; gi++) begin : g_unpack
      assign w_ch_data[gi] = bus.I[gi*N +: N];
    end
  endgenerate

  // The register can accept a new word when empty or when its content
  // leaves this cycle; this gives one transfer per cycle when streaming.
  assign w_free = ~r_fv | bus.FR;

  // Fixed mode: SEL wins only if it names an existing, valid channel.
  // An out-of-range SEL matches no k, so it yields no grant.
  always_comb begin
    w_fix_found = 1'b0;
    w_fix_idx   = '0;
    for (int k = 0; k < M; k++) begin
      if ((bus.SEL == SW'(k)) && bus.V[k]) begin
        w_fix_found = 1'b1;
        w_fix_idx   = SW'(k);
      end
    end
  end

  // Round-robin: scan ptr+1, ptr+2, ... wrapping after M-1 and ending at
  // ptr. The outer loop is the search order; the inner loop maps the
  // wrapped position to a constant channel index, so the winner is the
  // first valid channel found.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    for (int i = 1; i <= M; i++) begin
      for (int k = 0; k < M; k++) begin
        if (!w_rr_found && bus.V[k] &&
            ((int'(r_ptr) + i == k) || (int'(r_ptr) + i == k + M))) begin
          w_rr_found = 1'b1;
          w_rr_idx   = SW'(k);
        end
      end
    end
  end

  // Combine the mode choice with register availability
  assign w_gnt     = w_free & (bus.MD ? w_rr_found : w_fix_found);
  assign w_gnt_idx = bus.MD ? w_rr_idx : w_fix_idx;

  // One-hot ready toward the winning channel
  generate
    for (genvar gi = 0; gi < M; gi++) begin : g_ready
      assign w_gnt_oh[gi] = w_gnt && (w_gnt_idx == SW'(gi));
    end
  endgenerate

  // Ready is forced low while reset is asserted, so no channel believes
  // its word was taken by a register that is being cleared.
  assign bus.R = reset ? '0 : w_gnt_oh;

  // Select the granted channel's data
  always_comb begin
    w_gnt_data = '0;
    for (int k = 0; k < M; k++) begin
      if (w_gnt_oh[k]) begin
        w_gnt_data = w_ch_data[k];
      end
    end
  end

  // Output register: load on grant; go empty when free but nothing is
  // granted (F and S keep the old word); hold everything during a stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_f  <= '0;
      r_s  <= '0;
      r_fv <= 1'b0;
    end else if (w_free) begin
      if (w_gnt) begin
        r_f  <= w_gnt_data;
        r_s  <= w_gnt_idx;
        r_fv <= 1'b1;
      end else begin
        r_fv <= 1'b0;
      end
    end
  end

  // Pointer tracks the last round-robin winner. It resets to M-1 so that
  // channel 0 is searched first, and it does not move in fixed mode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= SW'(M - 1);
    end else if (w_gnt && bus.MD) begin
      r_ptr <= w_gnt_idx;
    end
  end

  assign bus.F  = r_f;
  assign bus.S  = r_s;
  assign bus.FV = r_fv;

endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed plus random bench for rr_mux_arb. The default configuration
// runs against a scoreboard queue of granted words. Two extra
// configurations (1-bit/2-channel and 16-bit/8-channel) run a random
// round-robin sweep with a reference model and a fairness bound.
module tb_rr_mux_arb;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rr_mux_arb_if #(.N(8),  .M(4), .SW(2)) bus0 ();
  rr_mux_arb_if #(.N(1),  .M(2), .SW(1)) bus1 ();
  rr_mux_arb_if #(.N(16), .M(8), .SW(3)) bus2 ();

  rr_mux_arb #(.N(8),  .M(4), .SW(2)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  rr_mux_arb #(.N(1),  .M(2), .SW(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  rr_mux_arb #(.N(16), .M(8), .SW(3)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] d;
    int         s;
  } item_t;

  item_t q[$];
  item_t m_last;
  int    m_ptr;
  bit    m_fv;
  logic [3:0] obs_r;

  // Sweep reference state, index 0 = small config, 1 = large config
  int         sp_ptr  [2];
  bit         sp_fv   [2];
  logic [15:0] sp_f   [2];
  int         sp_s    [2];
  int         sp_wait [2][8];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference search: first valid channel after ptr, modulo m
  function automatic int exp_rr(input logic [7:0] v, input int m, input int ptr);
    for (int i = 1; i <= m; i++) begin
      int j;
      j = (ptr + i) % m;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  function automatic int exp_fix(input logic [7:0] v, input int m, input int sel);
    if (sel < m && v[sel]) return sel;
    return -1;
  endfunction

  task automatic model_reset();
    m_fv     = 1'b0;
    m_ptr    = 3;
    q.delete();
    m_last.d = 8'h00;
    m_last.s = 0;
  endtask

  // One cycle on the main DUT: drive, check R, update scoreboard,
  // clock, check the output register.
  task automatic step(input string tag, input logic md, input logic [1:0] sel,
                      input logic [3:0] v, input logic fr, input logic [31:0] data);
    int    g;
    bit    free;
    item_t it;
    logic [3:0] exp_r;
    bus0.MD  = md;
    bus0.SEL = sel;
    bus0.V   = v;
    bus0.FR  = fr;
    bus0.I   = data;
    #1;
    free = !m_fv || fr;
    g = -1;
    if (free) g = md ? exp_rr({4'b0, v}, 4, m_ptr) : exp_fix({4'b0, v}, 4, int'(sel));
    exp_r = (g >= 0) ? 4'(1 << g) : 4'b0000;
    obs_r = bus0.R;
    check({tag, " R"}, 64'(bus0.R), 64'(exp_r));
    if (m_fv && fr) m_last = q.pop_front();
    if (g >= 0) begin
      it.d = data[g*8 +: 8];
      it.s = g;
      q.push_back(it);
      if (md) m_ptr = g;
    end
    if (free) m_fv = (g >= 0);
    @(posedge clk);
    #1;
    check({tag, " FV"}, 64'(bus0.FV), 64'(m_fv));
    if (m_fv) begin
      check({tag, " F"}, 64'(bus0.F), 64'(q[0].d));
      check({tag, " S"}, 64'(bus0.S), 64'(q[0].s));
    end else begin
      check({tag, " F"}, 64'(bus0.F), 64'(m_last.d));
      check({tag, " S"}, 64'(bus0.S), 64'(m_last.s));
    end
    $display("[TB] %s md=%0b sel=%0d v=%b fr=%0b R=%b -> FV=%0b F=%h S=%0d",
             tag, md, sel, v, fr, obs_r, bus0.FV, bus0.F, bus0.S);
  endtask

  // Sweep, before the edge: compare R with the model, track fairness
  // from the observed grants, and advance the model.
  task automatic sweep_pre(input int d, input int m, input int n, input logic [7:0] v,
                           input logic fr, input logic [127:0] din, input logic [7:0] r_obs);
    int g, gobs, maxw;
    bit free;
    logic [127:0] t;
    free = !sp_fv[d] || fr;
    g = free ? exp_rr(v, m, sp_ptr[d]) : -1;
    check($sformatf("sweep%0d R", d), 64'(r_obs), (g >= 0) ? (64'(1) << g) : 64'(0));
    gobs = -1;
    for (int k = 0; k < m; k++) if (r_obs[k]) gobs = k;
    maxw = 0;
    for (int k = 0; k < m; k++) begin
      if (!v[k] || k == gobs) sp_wait[d][k] = 0;
      else if (gobs >= 0) sp_wait[d][k]++;
      if (sp_wait[d][k] > maxw) maxw = sp_wait[d][k];
    end
    check($sformatf("sweep%0d fair", d), 64'(maxw < m), 64'(1));
    if (free) begin
      sp_fv[d] = (g >= 0);
      if (g >= 0) begin
        t = din >> (g * n);
        sp_f[d]   = t[15:0] & 16'((1 << n) - 1);
        sp_s[d]   = g;
        sp_ptr[d] = g;
      end
    end
  endtask

  task automatic sweep_post(input int d, input int m, input logic fv,
                            input int s, input logic [15:0] f);
    check($sformatf("sweep%0d FV", d), 64'(fv), 64'(sp_fv[d]));
    check($sformatf("sweep%0d S", d), 64'(s), 64'(sp_s[d]));
    check($sformatf("sweep%0d F", d), 64'(f), 64'(sp_f[d]));
    check($sformatf("sweep%0d S<M", d), 64'(s < m), 64'(1));
  endtask

  initial begin
    int exp_s0 [5] = '{0, 1, 2, 3, 0};
    int exp_s1 [4] = '{1, 3, 1, 3};
    logic [7:0] v1, v2;
    logic fr1, fr2;
    logic [1:0]   d1;
    logic [127:0] d2;

    // Quiet inputs everywhere
    bus0.I = '0; bus0.V = '0; bus0.MD = 1'b1; bus0.SEL = '0; bus0.FR = 1'b1;
    bus1.I = '0; bus1.V = '0; bus1.MD = 1'b1; bus1.SEL = '0; bus1.FR = 1'b1;
    bus2.I = '0; bus2.V = '0; bus2.MD = 1'b1; bus2.SEL = '0; bus2.FR = 1'b1;
    reset = 1'b1;
    model_reset();

    // Reset state, with valid offered so R must be held low by reset
    bus0.V = 4'b1111;
    #2;
    check("rst FV", 64'(bus0.FV), 64'(0));
    check("rst F",  64'(bus0.F),  64'(0));
    check("rst S",  64'(bus0.S),  64'(0));
    check("rst R",  64'(bus0.R),  64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    bus0.V = 4'b0000;
    $display("[TB] reset released");

    // All four channels valid: S walks 0,1,2,3,0 with one-hot R
    for (int i = 0; i < 5; i++) begin
      step("rr_all", 1'b1, 2'd0, 4'b1111, 1'b1, $urandom);
      check("rr_all seq", 64'(bus0.S), 64'(exp_s0[i]));
      check("rr_all onehot", 64'($onehot(obs_r)), 64'(1));
    end

    // Channels 1 and 3 only: alternate, 0 and 2 never readied
    for (int i = 0; i < 4; i++) begin
      step("rr_1010", 1'b1, 2'd0, 4'b1010, 1'b1, $urandom);
      check("rr_1010 seq", 64'(bus0.S), 64'(exp_s1[i]));
      check("rr_1010 R02", 64'(obs_r[0] | obs_r[2]), 64'(0));
    end

    // Fixed select of channel 2, then channel 2 not valid
    step("fix_sel2", 1'b0, 2'd2, 4'b0100, 1'b1, 32'h11A5_2233);
    check("fix_sel2 F", 64'(bus0.F), 64'(8'hA5));
    check("fix_sel2 S", 64'(bus0.S), 64'(2));
    step("fix_nov", 1'b0, 2'd2, 4'b1011, 1'b1, $urandom);
    check("fix_nov FV", 64'(bus0.FV), 64'(0));
    check("fix_nov R", 64'(obs_r), 64'(0));

    // Load 3C from channel 1, stall three cycles, then release
    step("stall_ld", 1'b0, 2'd1, 4'b0010, 1'b1, 32'h0000_3C00);
    for (int i = 0; i < 3; i++) begin
      step("stall", 1'b1, 2'd0, 4'b1111, 1'b0, $urandom);
      check("stall F", 64'(bus0.F), 64'(8'h3C));
      check("stall S", 64'(bus0.S), 64'(1));
      check("stall R", 64'(obs_r), 64'(0));
    end
    step("unstall", 1'b1, 2'd0, 4'b1111, 1'b1, 32'h4433_2211);
    check("unstall R", 64'(obs_r), 64'(4'b0001));
    check("unstall F", 64'(bus0.F), 64'(8'h11));

    // Reset in the middle of a stall discards the held word
    step("pre_rst", 1'b1, 2'd0, 4'b1111, 1'b0, $urandom);
    reset = 1'b1;
    #1;
    check("midrst FV", 64'(bus0.FV), 64'(0));
    check("midrst F",  64'(bus0.F),  64'(0));
    check("midrst S",  64'(bus0.S),  64'(0));
    check("midrst R",  64'(bus0.R),  64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    step("post_rst", 1'b1, 2'd0, 4'b1000, 1'b1, $urandom);
    check("post_rst S", 64'(bus0.S), 64'(3));
    check("post_rst FV", 64'(bus0.FV), 64'(1));

    // Random mix of modes, selects, valids and backpressure
    for (int i = 0; i < 40; i++) begin
      step("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0), $urandom);
    end
    bus0.V = '0;

    // Parameter sweep: both extra configurations in lock-step
    for (int d = 0; d < 2; d++) begin
      sp_ptr[d] = (d == 0) ? 1 : 7;
      sp_fv[d]  = 1'b0;
      sp_f[d]   = '0;
      sp_s[d]   = 0;
      for (int k = 0; k < 8; k++) sp_wait[d][k] = 0;
    end
    for (int c = 0; c < 100; c++) begin
      v1  = 8'($urandom_range(0, 3));
      v2  = 8'($urandom_range(0, 255));
      fr1 = 1'($urandom_range(0, 3) != 0);
      fr2 = 1'($urandom_range(0, 3) != 0);
      d1  = 2'($urandom);
      d2  = {$urandom, $urandom, $urandom, $urandom};
      bus1.V = v1[1:0]; bus1.FR = fr1; bus1.I = d1;
      bus2.V = v2;      bus2.FR = fr2; bus2.I = d2;
      #1;
      sweep_pre(0, 2, 1,  v1, fr1, {126'b0, d1}, {6'b0, bus1.R});
      sweep_pre(1, 8, 16, v2, fr2, d2, bus2.R);
      @(posedge clk); #1;
      sweep_post(0, 2, bus1.FV, int'(bus1.S), {15'b0, bus1.F});
      sweep_post(1, 8, bus2.FV, int'(bus2.S), bus2.F);
      $display("[TB] sweep %0d: small v=%b S=%0d FV=%0b | large v=%b S=%0d FV=%0b",
               c, v1[1:0], bus1.S, bus1.FV, v2, bus2.S, bus2.FV);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
